// File: rtl/mem_pkg.sv
// mem_pkg: load/store size encodings and responder FSM states shared with the core
package mem_pkg;
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane replication/byte-enables and load lane select with extension
module lsu_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata
);
   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   // store side: replicate right-aligned data into every lane, mask selects the target lane
   always_comb begin
      be    = size[1:0] == 2'b00 ? 4'b0001 << lane : size[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
      wword = size[1:0] == 2'b00 ? {4{wdata[7:0]}} : size[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
   end
   // load side: pick the addressed byte/half and extend by size; illegal sizes read as zero
   always_comb begin
      rbyte = rword[{lane, 3'b000} +: 8];
      rhalf = lane[1] ? rword[31:16] : rword[15:0];
      rdata = size == SZ_B  ? {{24{rbyte[7]}}, rbyte} :
              size == SZ_BU ? {24'h0, rbyte} :
              size == SZ_H  ? {{16{rhalf[15]}}, rhalf} :
              size == SZ_HU ? {16'h0, rhalf} :
              size == SZ_W  ? rword : 32'h0;
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with programmable wait states
module dmem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WC   = 4'(WAIT_CYCLES);
   state_t      state;
   logic [3:0]  cnt;
   logic        we_q;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic [31:0] wdata_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic        accept;
   logic        commit;
   logic        c_we;
   logic [31:0] c_addr;
   logic [2:0]  c_size;
   logic [31:0] c_wdata;
   logic [31:0] off;
   logic [AW-1:0] idx;
   logic        err;
   logic [3:0]  be;
   logic [31:0] wword;
   logic [31:0] rdata;
   // with zero wait states the accept edge is also the commit edge, so decode straight from the ports in IDLE
   always_comb begin
      accept  = req_valid & req_ready;
      commit  = state == IDLE ? accept && WC == 4'd0 : state == WAIT && cnt == WC;
      c_we    = state == IDLE ? req_we    : we_q;
      c_addr  = state == IDLE ? req_addr  : addr_q;
      c_size  = state == IDLE ? req_size  : size_q;
      c_wdata = state == IDLE ? req_wdata : wdata_q;
      off     = c_addr - BASE_ADDR;
      idx     = off[AW+1:2];
      err     = off >= SPAN ||
                !(c_size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU}) ||
                (c_size[1:0] == 2'b01 && c_addr[0]) ||
                (c_size == SZ_W && c_addr[1:0] != 2'b00);
   end
   lsu_lane_align u_align (
      .size  (c_size),
      .lane  (c_addr[1:0]),
      .wdata (c_wdata),
      .rword (mem[idx]),
      .be    (be),
      .wword (wword),
      .rdata (rdata)
   );
   // RAM: byte-masked read-modify-write on the commit edge only; contents survive reset
   always_ff @(posedge clk)
      if (commit && c_we && !err && !rst)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
   // FSM, wait counter, request latch and registered handshake/response outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         size_q    <= 3'b0;
         wdata_q   <= 32'h0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
         end
         if (commit) begin
            state     <= RESP;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= err || c_we ? 32'h0 : rdata;
         end else if (state == IDLE && accept) begin
            state     <= WAIT;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
         end else if (state == WAIT) begin
            cnt <= cnt + 4'd1;
         end else if (state == RESP && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
         end
      end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the responder with 2 wait states and a zero-wait build
module tb_dmem_responder;
   import mem_pkg::*;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_size = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;
   logic        z_req_valid = 1'b0, z_req_ready, z_req_we = 1'b0;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic [2:0]  z_req_size = '0;
   logic        z_rsp_valid, z_rsp_err;
   logic        z_rsp_ready = 1'b1;
   logic [31:0] z_rsp_rdata;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_z (
      .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
      .req_addr(z_req_addr), .req_size(z_req_size), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid),
      .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full transaction on the 2-wait DUT; ports are scrambled after accept to show they are latched
   task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic er, output int lat);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata; rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_size = 3'b111; req_wdata = 32'h5555_5555;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 00000000", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(1'b1, 32'h10, SZ_W, 32'h1111_1111, rd, er, lat);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = SZ_W; req_wdata = 32'hDEAD_BEEF;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstwait_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstwait_req_ready: got %b want 1", req_ready); end
      tick();
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstwait_rsp_valid_held: got %b want 0", rsp_valid); end
      rst = 1'b0;
      tick();
      xact(1'b0, 32'h10, SZ_W, 32'h0, rd, er, lat);
      checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rstwait_reload: got %h want 11111111", rd); end
   endtask

   task automatic test_word();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(1'b1, 32'h20, SZ_W, 32'h1234_5678, rd, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_rsp: got %h/%b want 00000000/0", rd, er); end
      xact(1'b0, 32'h20, SZ_W, 32'h0, rd, er, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL lw_rsp: got %h/%b want 12345678/0", rd, er); end
   endtask

   task automatic test_lanes();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        we   [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      logic [31:0] addr [10] = '{32'h23, 32'h23, 32'h23, 32'h20, 32'h22, 32'h22, 32'h22, 32'h20, 32'h20, 32'h20};
      logic [2:0]  size [10] = '{SZ_B, SZ_B, SZ_BU, SZ_W, SZ_H, SZ_H, SZ_HU, SZ_H, SZ_B, SZ_W};
      logic [31:0] wd   [10] = '{32'h0000_0080, 0, 0, 0, 32'h0000_BEEF, 0, 0, 0, 32'hAAAA_AA7F, 0};
      logic [31:0] exp  [10] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h8034_5678, 32'h0,
                                 32'hFFFF_BEEF, 32'h0000_BEEF, 32'h0000_5678, 32'h0, 32'hBEEF_567F};
      for (int i = 0; i < 10; i++) begin
         xact(we[i], addr[i], size[i], wd[i], rd, er, lat);
         checks++;
         if (rd !== exp[i] || er !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL lane_%0d: got %h/%b/%0d want %h/0/3", i, rd, er, lat, exp[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        we   [6] = '{0, 1, 1, 0, 0, 1};
      logic [31:0] addr [6] = '{32'h21, 32'h26, 32'h400, 32'h400, 32'h20, 32'h20};
      logic [2:0]  size [6] = '{SZ_H, SZ_W, SZ_W, SZ_W, 3'b011, 3'b011};
      logic [31:0] rba  [3] = '{32'h24, 32'h0, 32'h20};
      logic [31:0] rbv  [3] = '{32'hCAFE_F00D, 32'h0BAD_F00D, 32'hBEEF_567F};
      xact(1'b1, 32'h24, SZ_W, 32'hCAFE_F00D, rd, er, lat);
      xact(1'b1, 32'h00, SZ_W, 32'h0BAD_F00D, rd, er, lat);
      for (int i = 0; i < 6; i++) begin
         xact(we[i], addr[i], size[i], 32'hFFFF_FFFF, rd, er, lat);
         checks++;
         if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
            errors++;
            $display("FAIL err_%0d: got %h/%b/%0d want 00000000/1/3", i, rd, er, lat);
         end
      end
      for (int i = 0; i < 3; i++) begin
         xact(1'b0, rba[i], SZ_W, 32'h0, rd, er, lat);
         checks++;
         if (rd !== rbv[i] || er !== 1'b0) begin
            errors++;
            $display("FAIL err_readback_%0d: got %h/%b want %h/0", i, rd, er, rbv[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = SZ_W; rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", n); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF_567F || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: got v=%b d=%h rdy=%b want v=1 d=beef567f rdy=0", i, rsp_valid, rsp_rdata, req_ready);
         end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic        we   [4] = '{1, 0, 1, 0};
      logic [31:0] addr [4] = '{32'h40, 32'h40, 32'h41, 32'h40};
      logic [2:0]  size [4] = '{SZ_W, SZ_W, SZ_B, SZ_W};
      logic [31:0] wd   [4] = '{32'hA5A5_A5A5, 0, 32'h0000_0011, 0};
      logic [31:0] exp  [4] = '{32'h0, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_11A5};
      int k = 0;
      int last = 0;
      z_req_valid = 1'b1; z_req_we = we[0]; z_req_addr = addr[0]; z_req_size = size[0]; z_req_wdata = wd[0];
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (z_rsp_valid && k < 4) begin
            checks++;
            if (z_rsp_rdata !== exp[k] || z_rsp_err !== 1'b0 || c - last !== (k == 0 ? 1 : 2)) begin
               errors++;
               $display("FAIL b2b_%0d: got %h/%b gap %0d want %h/0 gap %0d", k, z_rsp_rdata, z_rsp_err, c - last, exp[k], k == 0 ? 1 : 2);
            end
            last = c;
            k++;
            if (k < 4) begin
               z_req_we = we[k]; z_req_addr = addr[k]; z_req_size = size[k]; z_req_wdata = wd[k];
            end else z_req_valid = 1'b0;
         end
      end
      z_req_valid = 1'b0;
      checks++; if (k !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", k); end
   endtask

   initial begin
      test_reset();
      test_reset_in_wait();
      test_word();
      test_lanes();
      test_errors();
      test_backpressure();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
